gf_operand_loader: RTL and testbench

Serial front-end and result serializer for the GF arithmetic datapath. Collects operand A and operand B from a single-bit serial input, presents them in parallel, and asserts the datapath enable for a fixed number of compute cycles. It then captures the double-width product and streams it out serially. It sits between the chip pins and the carry-less compute block, replacing free-running shift registers with framed, handshaked loading.

---
 rtl/gf_operand_loader.sv | 177 +++++++++++++++++
 tb/tb_gf_operand_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gf_operand_loader.sv
// Framed serial operand loader and result serializer for the GF datapath.
// Optional even-parity frame check is enabled by defining GF_LOADER_PARITY_EN.
module gf_operand_loader #(
    parameter int DATA_WIDTH     = 32,
    parameter int COMPUTE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    in_bit,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   op_a,
    output logic [DATA_WIDTH-1:0]   op_b,
    output logic                    op_enable,
    input  logic [2*DATA_WIDTH-1:0] result_in,
    output logic                    out_valid,
    output logic                    out_bit,
    output logic                    out_last,
    output logic                    frame_err
);

    localparam int RES_W = 2 * DATA_WIDTH;
    localparam int CNT_W = $clog2(RES_W) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
`ifdef GF_LOADER_PARITY_EN
        CHECK,
`endif
        COMPUTE,
        SHIFT
    } state_t;

    state_t           state, nxt;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [7:0]       ccnt, ccnt_d;
    logic [RES_W-2:0] sreg;
    logic             take;
    logic             ready_d, enable_d, valid_d, last_d;
    logic             parity_bad;

    assign take = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ccnt      <= '0;
            in_ready  <= 1'b1;
            op_enable <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= cnt_d;
            ccnt      <= ccnt_d;
            in_ready  <= ready_d;
            op_enable <= enable_d;
            out_valid <= valid_d;
            out_last  <= last_d;
        end
    end

    always_comb begin
        nxt        = state;
        cnt_d      = cnt;
        ccnt_d     = ccnt;
        parity_bad = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    nxt   = LOAD_A;
                    cnt_d = CNT_W'(1);
                end
            end
            LOAD_A: begin
                if (take) begin
                    if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        nxt   = LOAD_B;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (take) begin
                    if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
`ifdef GF_LOADER_PARITY_EN
                        nxt    = CHECK;
`else
                        nxt    = COMPUTE;
`endif
                        cnt_d  = '0;
                        ccnt_d = '0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
`ifdef GF_LOADER_PARITY_EN
            CHECK: begin
                if (take) begin
                    // Even parity: the XOR over both operands and the parity bit must be zero.
                    if (^{op_a, op_b, in_bit}) begin
                        nxt        = IDLE;
                        parity_bad = 1'b1;
                    end else begin
                        nxt    = COMPUTE;
                        ccnt_d = '0;
                    end
                end
            end
`endif
            COMPUTE: begin
                if (ccnt == 8'(COMPUTE_CYCLES - 1)) begin
                    nxt   = SHIFT;
                    cnt_d = CNT_W'(1);
                end else begin
                    ccnt_d = ccnt + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(RES_W)) begin
                    nxt   = IDLE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the next state.
    always_comb begin
        ready_d  = !(nxt == COMPUTE || nxt == SHIFT);
        enable_d = (nxt == COMPUTE);
        valid_d  = (nxt == SHIFT);
        last_d   = valid_d && (cnt_d == CNT_W'(RES_W));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a    <= '0;
            op_b    <= '0;
            sreg    <= '0;
            out_bit <= 1'b0;
        end else begin
            if (take && (state == IDLE || state == LOAD_A))
                op_a <= {op_a[DATA_WIDTH-2:0], in_bit};
            if (take && state == LOAD_B)
                op_b <= {op_b[DATA_WIDTH-2:0], in_bit};
            if (state == COMPUTE && nxt == SHIFT) begin
                out_bit <= result_in[0];
                sreg    <= result_in[RES_W-1:1];
            end else if (state == SHIFT && nxt == SHIFT) begin
                out_bit <= sreg[0];
                sreg    <= {1'b0, sreg[RES_W-2:1]};
            end else begin
                out_bit <= 1'b0;
            end
        end
    end

`ifdef GF_LOADER_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) frame_err <= 1'b0;
        else       frame_err <= parity_bad;
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_gf_operand_loader.sv
// Directed + randomized bench for gf_operand_loader, checked against a frame-level model.
module tb_gf_operand_loader;

    localparam int W  = 8;
    localparam int CC = 2;
`ifdef GF_LOADER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_bit, in_ready;
    logic [W-1:0]  op_a, op_b;
    logic          op_enable;
    logic [2*W-1:0] result_in;
    logic          out_valid, out_bit, out_last, frame_err;

    logic          in_valid2, in_bit2, in_ready2;
    logic [31:0]   op_a2, op_b2;
    logic          op_enable2;
    logic [63:0]   result_in2;
    logic          out_valid2, out_bit2, out_last2, frame_err2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gf_operand_loader #(.DATA_WIDTH(W), .COMPUTE_CYCLES(CC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .op_a(op_a), .op_b(op_b), .op_enable(op_enable),
        .result_in(result_in), .out_valid(out_valid), .out_bit(out_bit),
        .out_last(out_last), .frame_err(frame_err)
    );

    gf_operand_loader #(.DATA_WIDTH(32), .COMPUTE_CYCLES(1)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_bit(in_bit2),
        .in_ready(in_ready2), .op_a(op_a2), .op_b(op_b2), .op_enable(op_enable2),
        .result_in(result_in2), .out_valid(out_valid2), .out_bit(out_bit2),
        .out_last(out_last2), .frame_err(frame_err2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_noise(input bit noise);
        in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        in_bit   = 1'($urandom_range(0, 1));
    endtask

    // gap_mode: 0 contiguous, 1 every other cycle idle, 2 random gaps
    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [2*W-1:0] res, input int gap_mode,
                              input bit bad_par, input bit noise);
        bit q[$];
        int sent = 0;
        int tries = 0;
        bit v;
        for (int i = W - 1; i >= 0; i--) q.push_back(a[i]);
        for (int i = W - 1; i >= 0; i--) q.push_back(b[i]);
        if (PAR) q.push_back((^a) ^ (^b) ^ bad_par);
        result_in = res;
        while (sent < q.size() && tries < 400) begin
            if (gap_mode == 0)      v = 1'b1;
            else if (gap_mode == 1) v = (tries % 2 == 0);
            else                    v = 1'($urandom_range(0, 1));
            in_valid = v;
            in_bit   = v ? q[sent] : 1'($urandom_range(0, 1));
            if (v) begin
                chk("ready_load", in_ready, 1);
                sent++;
            end
            tries++;
            step();
        end
        in_valid = 1'b0;
        chk("load_done", sent, q.size());
        if (bad_par) begin
            chk("perr_pulse", frame_err, 1);
            chk("perr_noen", op_enable, 0);
            chk("perr_ready", in_ready, 1);
            step();
            chk("perr_clear", frame_err, 0);
            chk("perr_noen2", op_enable, 0);
            return;
        end
        for (int i = 0; i < CC; i++) begin
            drive_noise(noise);
            chk("enable", op_enable, 1);
            chk("ready_comp", in_ready, 0);
            chk("valid_comp", out_valid, 0);
            chk("op_a", op_a, a);
            chk("op_b", op_b, b);
            chk("ferr_comp", frame_err, 0);
            step();
        end
        for (int j = 0; j < 2 * W; j++) begin
            drive_noise(noise);
            chk("out_valid", out_valid, 1);
            chk("out_bit", out_bit, res[j]);
            chk("out_last", out_last, (j == 2 * W - 1));
            chk("enable_off", op_enable, 0);
            chk("ready_shift", in_ready, 0);
            chk("op_a_hold", op_a, a);
            chk("op_b_hold", op_b, b);
            step();
        end
        in_valid = 1'b0;
        chk("ready_back", in_ready, 1);
        chk("valid_off", out_valid, 0);
        chk("last_off", out_last, 0);
    endtask

    initial begin
        logic [31:0] a2, b2;
        logic [63:0] res2, got2;
        bit q2[$];
        int en_cnt, val_cnt, last_cnt;

        reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; result_in = '0;
        in_valid2 = 1'b0; in_bit2 = 1'b0; result_in2 = '0;
        step(); step();
        chk("rst_ready", in_ready, 1);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_enable", op_enable, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_bit", out_bit, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ferr", frame_err, 0);
        reset = 1'b0;
        step();

        send_frame(8'h53, 8'hCA, 16'hBEEF, 0, 1'b0, 1'b0);
        send_frame(8'h53, 8'hCA, 16'hBEEF, 1, 1'b0, 1'b0);
        send_frame(8'h5A, 8'h3C, 16'($urandom), 0, 1'b0, 1'b1);
        send_frame(8'h01, 8'h80, 16'($urandom), 0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            send_frame(8'($urandom), 8'($urandom), 16'($urandom), 2, 1'b0, 1'b1);

        // Abort a frame after 12 accepted bits with an asynchronous reset.
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("arst_ready", in_ready, 1);
        chk("arst_op_a", op_a, 0);
        chk("arst_op_b", op_b, 0);
        chk("arst_enable", op_enable, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_last", out_last, 0);
        step();
        reset = 1'b0;
        step();
        send_frame(8'hFF, 8'h00, 16'($urandom), 0, 1'b0, 1'b0);

        if (PAR) begin
            send_frame(8'h53, 8'hCA, 16'h1234, 0, 1'b1, 1'b0);
            send_frame(8'h53, 8'hCA, 16'hBEEF, 0, 1'b0, 1'b0);
        end

        // Wide instance: single-cycle enable, 64-bit serial result.
        a2 = $urandom; b2 = $urandom; res2 = {$urandom, $urandom};
        result_in2 = res2;
        for (int i = 31; i >= 0; i--) q2.push_back(a2[i]);
        for (int i = 31; i >= 0; i--) q2.push_back(b2[i]);
        if (PAR) q2.push_back((^a2) ^ (^b2));
        foreach (q2[i]) begin
            in_valid2 = 1'b1;
            in_bit2   = q2[i];
            step();
        end
        in_valid2 = 1'b0;
        chk("w_op_a", op_a2, a2);
        chk("w_op_b", op_b2, b2);
        chk("w_enable_first", op_enable2, 1);
        en_cnt = 0; val_cnt = 0; last_cnt = 0; got2 = '0;
        for (int c = 0; c < 100; c++) begin
            if (op_enable2) en_cnt++;
            if (out_valid2) begin
                if (val_cnt < 64) got2[val_cnt] = out_bit2;
                val_cnt++;
            end
            if (out_last2) last_cnt++;
            step();
        end
        chk("w_enable_cnt", en_cnt, 1);
        chk("w_valid_cnt", val_cnt, 64);
        chk("w_last_cnt", last_cnt, 1);
        chk("w_result", got2, res2);
        chk("w_ready", in_ready2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
